// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// Module : dmem_arbiter_pkg
// Purpose: Shared definitions for the data-memory arbiter: memory access size
//          codes (identical to those used by data_memory and control) and the
//          arbiter state encoding.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

  // Access size codes understood by data_memory.
  localparam logic [1:0] MEM_MODE_BYTE = 2'b00;
  localparam logic [1:0] MEM_MODE_HALF = 2'b01;
  localparam logic [1:0] MEM_MODE_WORD = 2'b10;

  // Arbiter states.
  typedef enum logic [0:0] {
    ST_CORE_OWN  = 1'b0,
    ST_DBG_FORCE = 1'b1
  } arb_state_e;

endpackage : dmem_arbiter_pkg

`default_nettype wire

// File: rtl/dmem_arbiter_starvation_counter.sv
// ============================================================================
// Module : dmem_arbiter_starvation_counter
// Purpose: Saturating wait counter with synchronous clear. Also reports whether
//          the value being loaded on the next edge equals the limit, so the
//          owning FSM can enter its forced state in step with the counter.
// Ports  : clock, reset     - clock, synchronous active-high reset
//          i_inc            - count up (saturates at LIMIT)
//          i_clr            - clear to zero (dominates i_inc)
//          o_count          - current count
//          o_tc_next        - next count value equals LIMIT
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter_starvation_counter #(
  parameter int LIMIT = 8,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count,
  output logic         o_tc_next
);

  localparam logic [W-1:0] C_LIMIT = W'(LIMIT);
  localparam logic [W-1:0] C_ONE   = W'(1);

  logic [W-1:0] r_count;
  logic [W-1:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (i_clr) begin
      w_count_next = '0;
    end else if (i_inc && (r_count != C_LIMIT)) begin
      w_count_next = r_count + C_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count   = r_count;
  // Reset overrides the next value, so never report a terminal count then.
  assign o_tc_next = !reset && (w_count_next == C_LIMIT);

endmodule : dmem_arbiter_starvation_counter

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module : dmem_arbiter
// Purpose: Shares the single data_memory port between the core (EX stage) and
//          a debug/loader requester. The core has fixed priority; after
//          STARVE_LIMIT consecutive denied debug cycles the debug side gets
//          one forced grant and the core is stalled for that single cycle.
// Ports  : clock, reset                  - clock, synchronous active-high reset
//          i_core_req/addr/wdata/wren/mode - core access presented in EX
//          o_core_stall                  - core must hold EX and re-present
//          i_dbg_req/addr/wdata/wren     - debug access, held until granted
//          o_dbg_gnt                     - debug access accepted this cycle
//          o_dbg_rvalid, o_dbg_rdata     - debug read return (one cycle later)
//          o_mem_address/data/wren/mode  - data_memory input pins
//          i_mem_q                       - data_memory read data (1-cycle latency)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_core_req,
  input  logic [XLEN-1:0] i_core_addr,
  input  logic [XLEN-1:0] i_core_wdata,
  input  logic            i_core_wren,
  input  logic [1:0]      i_core_mode,
  output logic            o_core_stall,
  input  logic            i_dbg_req,
  input  logic [XLEN-1:0] i_dbg_addr,
  input  logic [XLEN-1:0] i_dbg_wdata,
  input  logic            i_dbg_wren,
  output logic            o_dbg_gnt,
  output logic            o_dbg_rvalid,
  output logic [XLEN-1:0] o_dbg_rdata,
  output logic [XLEN-1:0] o_mem_address,
  output logic [XLEN-1:0] o_mem_data,
  output logic            o_mem_wren,
  output logic [1:0]      o_mem_mode,
  input  logic [XLEN-1:0] i_mem_q
);

  localparam int             CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e       r_state;
  arb_state_e       w_state_next;
  logic [CNT_W-1:0] w_wait_cnt;
  logic             w_tc_next;
  logic             w_forced;
  logic             w_dbg_win;
  logic             w_core_win;
  logic             w_cnt_inc;
  logic             w_cnt_clr;
  logic             r_rd_owner;
  logic [XLEN-1:0]  r_rdata;

  dmem_arbiter_starvation_counter #(
    .LIMIT (STARVE_LIMIT),
    .W     (CNT_W)
  ) u_starve_cnt (
    .clock     (clock),
    .reset     (reset),
    .i_inc     (w_cnt_inc),
    .i_clr     (w_cnt_clr),
    .o_count   (w_wait_cnt),
    .o_tc_next (w_tc_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_CORE_OWN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus owner selection. No grant is issued while reset is high,
  // so a request held across reset cannot leak an access into memory.
  always_comb begin
    w_state_next = r_state;
    w_forced     = 1'b0;
    w_dbg_win    = 1'b0;
    w_core_win   = 1'b0;

    case (r_state)
      ST_CORE_OWN: begin
        if (w_tc_next) begin
          w_state_next = ST_DBG_FORCE;
        end
      end
      ST_DBG_FORCE: begin
        // Either the forced grant or a dropped request clears the counter,
        // so this state lasts exactly one cycle.
        w_forced     = i_dbg_req && (w_wait_cnt == C_LIMIT);
        w_state_next = ST_CORE_OWN;
      end
      default: begin
        w_state_next = ST_CORE_OWN;
      end
    endcase

    if (!reset) begin
      w_dbg_win  = i_dbg_req && (w_forced || !i_core_req);
      w_core_win = i_core_req && !w_dbg_win;
    end
  end

  assign w_cnt_inc = i_dbg_req && !w_dbg_win;
  assign w_cnt_clr = w_dbg_win || !i_dbg_req;

  // Memory pins: debug accesses are always full words; when idle the core
  // fields pass through but no write is issued.
  assign o_mem_address = w_dbg_win ? i_dbg_addr  : i_core_addr;
  assign o_mem_data    = w_dbg_win ? i_dbg_wdata : i_core_wdata;
  assign o_mem_mode    = w_dbg_win ? MEM_MODE_WORD : i_core_mode;
  assign o_mem_wren    = w_dbg_win ? i_dbg_wren : (w_core_win && i_core_wren);

  assign o_dbg_gnt     = w_dbg_win;
  assign o_core_stall  = w_dbg_win && i_core_req;

  // Read return: the owner bit marks that the q arriving this cycle belongs
  // to the debug side. The value is forwarded in its valid cycle and then
  // held until the next debug read returns.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_owner <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_rd_owner <= w_dbg_win && !i_dbg_wren;
      if (r_rd_owner) begin
        r_rdata <= i_mem_q;
      end
    end
  end

  // A read granted just before reset must not report valid during reset.
  assign o_dbg_rvalid = r_rd_owner && !reset;
  assign o_dbg_rdata  = reset ? '0 : (r_rd_owner ? i_mem_q : r_rdata);

endmodule : dmem_arbiter

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module : tb_dmem_arbiter
// Purpose: Directed self-checking bench for dmem_arbiter with a small
//          registered-input data memory model behind the arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  localparam int XLEN = 32;
  localparam int LIM  = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic            core_req;
  logic [XLEN-1:0] core_addr;
  logic [XLEN-1:0] core_wdata;
  logic            core_wren;
  logic [1:0]      core_mode;
  logic            core_stall;
  logic            dbg_req;
  logic [XLEN-1:0] dbg_addr;
  logic [XLEN-1:0] dbg_wdata;
  logic            dbg_wren;
  logic            dbg_gnt;
  logic            dbg_rvalid;
  logic [XLEN-1:0] dbg_rdata;
  logic [XLEN-1:0] mem_address;
  logic [XLEN-1:0] mem_data;
  logic            mem_wren;
  logic [1:0]      mem_mode;
  logic [XLEN-1:0] mem_q;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(
    .XLEN         (XLEN),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .i_core_req    (core_req),
    .i_core_addr   (core_addr),
    .i_core_wdata  (core_wdata),
    .i_core_wren   (core_wren),
    .i_core_mode   (core_mode),
    .o_core_stall  (core_stall),
    .i_dbg_req     (dbg_req),
    .i_dbg_addr    (dbg_addr),
    .i_dbg_wdata   (dbg_wdata),
    .i_dbg_wren    (dbg_wren),
    .o_dbg_gnt     (dbg_gnt),
    .o_dbg_rvalid  (dbg_rvalid),
    .o_dbg_rdata   (dbg_rdata),
    .o_mem_address (mem_address),
    .o_mem_data    (mem_data),
    .o_mem_wren    (mem_wren),
    .o_mem_mode    (mem_mode),
    .i_mem_q       (mem_q)
  );

  always #5 clock = ~clock;

  // Data memory model: input registers, q valid one cycle after issue.
  logic [XLEN-1:0] mem [0:255];
  always @(posedge clock) begin
    if (mem_wren) mem[mem_address[9:2]] <= mem_data;
    mem_q <= mem[mem_address[9:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 32'hDEADBEEF;  // byte address 0x40
    mem_q      = '0;

    // ---- Reset with both requesters active ----
    reset      = 1'b1;
    core_req   = 1'b1;
    core_addr  = 32'h0000_0010;
    core_wdata = 32'h0;
    core_wren  = 1'b0;
    core_mode  = 2'b10;
    dbg_req    = 1'b1;
    dbg_addr   = 32'h0000_0040;
    dbg_wdata  = 32'h0;
    dbg_wren   = 1'b0;

    next_cycle();
    settle();
    check("rst_stall",  {31'd0, core_stall}, 32'd0);
    check("rst_gnt",    {31'd0, dbg_gnt},    32'd0);
    check("rst_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    check("rst_rdata",  dbg_rdata,           32'd0);
    check("rst_wren",   {31'd0, mem_wren},   32'd0);
    next_cycle();
    reset = 1'b0;

    // First cycle after reset: core owns the port.
    settle();
    check("post_rst_gnt",   {31'd0, dbg_gnt},    32'd0);
    check("post_rst_stall", {31'd0, core_stall}, 32'd0);
    check("post_rst_addr",  mem_address,         32'h10);
    next_cycle();
    check("post_rst_cnt", 32'(dut.w_wait_cnt), 32'd1);
    dbg_req = 1'b0;
    next_cycle();
    check("cnt_cleared", 32'(dut.w_wait_cnt), 32'd0);

    // ---- Debug read at 0x40 with core idle ----
    core_req = 1'b0;
    dbg_req  = 1'b1;
    dbg_addr = 32'h0000_0040;
    dbg_wren = 1'b0;
    settle();
    check("rd_gnt",   {31'd0, dbg_gnt},    32'd1);
    check("rd_mode",  {30'd0, mem_mode},   32'd2);
    check("rd_wren",  {31'd0, mem_wren},   32'd0);
    check("rd_addr",  mem_address,         32'h40);
    check("rd_stall", {31'd0, core_stall}, 32'd0);
    next_cycle();
    dbg_req = 1'b0;
    settle();
    check("rd_rvalid", {31'd0, dbg_rvalid}, 32'd1);
    check("rd_rdata",  dbg_rdata,           32'hDEADBEEF);
    next_cycle();
    settle();
    check("rd_rvalid_drop", {31'd0, dbg_rvalid}, 32'd0);
    check("rd_rdata_hold",  dbg_rdata,           32'hDEADBEEF);
    next_cycle();

    // ---- Starved debug write; forced grant on 9th cycle ----
    core_req  = 1'b1;
    core_wren = 1'b0;
    core_addr = 32'h0000_0100;
    core_mode = 2'b10;
    dbg_req   = 1'b1;
    dbg_wren  = 1'b1;
    dbg_addr  = 32'h0000_0080;
    dbg_wdata = 32'h1234_5678;
    for (int c = 1; c <= LIM; c++) begin
      settle();
      check("wait_gnt_stall", {30'd0, dbg_gnt, core_stall}, 32'd0);
      next_cycle();
    end
    settle();
    check("force_gnt",   {31'd0, dbg_gnt},    32'd1);
    check("force_stall", {31'd0, core_stall}, 32'd1);
    check("force_wren",  {31'd0, mem_wren},   32'd1);
    check("force_addr",  mem_address,         32'h80);
    check("force_data",  mem_data,            32'h1234_5678);
    next_cycle();
    // Core re-presents, now as a store; debug has been served.
    dbg_req    = 1'b0;
    dbg_wren   = 1'b0;
    core_wren  = 1'b1;
    core_addr  = 32'h0000_0104;
    core_wdata = 32'hCAFE_F00D;
    settle();
    check("after_stall",  {31'd0, core_stall}, 32'd0);
    check("after_gnt",    {31'd0, dbg_gnt},    32'd0);
    check("after_wren",   {31'd0, mem_wren},   32'd1);
    check("after_addr",   mem_address,         32'h104);
    check("after_data",   mem_data,            32'hCAFE_F00D);
    next_cycle();

    // ---- Core byte store, no debug traffic ----
    core_req   = 1'b1;
    core_wren  = 1'b1;
    core_mode  = 2'b00;
    core_addr  = 32'h0000_0203;
    core_wdata = 32'h0000_00AB;
    settle();
    check("byte_addr",   mem_address,         32'h203);
    check("byte_data",   mem_data,            32'hAB);
    check("byte_wren",   {31'd0, mem_wren},   32'd1);
    check("byte_mode",   {30'd0, mem_mode},   32'd0);
    check("byte_gnt",    {31'd0, dbg_gnt},    32'd0);
    check("byte_stall",  {31'd0, core_stall}, 32'd0);
    check("byte_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    next_cycle();

    // ---- Forced state reached, then debug drops ----
    core_wren = 1'b0;
    core_mode = 2'b10;
    core_addr = 32'h0000_0300;
    dbg_req   = 1'b1;
    dbg_addr  = 32'h0000_0040;
    dbg_wren  = 1'b0;
    for (int c = 1; c <= LIM; c++) next_cycle();
    dbg_req = 1'b0;
    settle();
    check("drop_cnt_at_limit", 32'(dut.w_wait_cnt),   32'(LIM));
    check("drop_gnt",          {31'd0, dbg_gnt},      32'd0);
    check("drop_stall",        {31'd0, core_stall},   32'd0);
    check("drop_addr",         mem_address,           32'h300);
    next_cycle();
    check("drop_cnt_clear",    32'(dut.w_wait_cnt),   32'd0);
    settle();
    check("drop_no_stall_next", {31'd0, core_stall},  32'd0);
    next_cycle();

    // ---- Debug read interrupted by reset, then reissued ----
    core_req = 1'b0;
    dbg_req  = 1'b1;
    dbg_addr = 32'h0000_0080;
    dbg_wren = 1'b0;
    settle();
    check("rr_gnt1", {31'd0, dbg_gnt}, 32'd1);
    next_cycle();
    reset   = 1'b1;
    dbg_req = 1'b0;
    settle();
    check("rr_rvalid_rst", {31'd0, dbg_rvalid}, 32'd0);
    check("rr_rdata_rst",  dbg_rdata,           32'd0);
    next_cycle();
    reset   = 1'b0;
    settle();
    check("rr_rvalid_post", {31'd0, dbg_rvalid}, 32'd0);
    next_cycle();
    dbg_req = 1'b1;
    settle();
    check("rr_gnt2", {31'd0, dbg_gnt}, 32'd1);
    next_cycle();
    dbg_req = 1'b0;
    settle();
    check("rr_rvalid", {31'd0, dbg_rvalid}, 32'd1);
    check("rr_rdata",  dbg_rdata,           32'h1234_5678);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dmem_arbiter

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the pipeline's memory access (issued from the EX stage, because the memory has input registers) and a debug/loader requester (UART program loader or debug probe).
- The core has fixed priority. A starvation guard forces one debug grant after a bounded wait and stalls the core for that single cycle.
- Sits between the core and data_memory; all data_memory input pins are driven from this block.

Parameters:
- XLEN, 32, address/data width.
- STARVE_LIMIT, 8, consecutive denied debug cycles before a forced debug grant; legal range 1..255.

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- core_req  in  1  core memory access this cycle (load or store in EX)
- core_addr  in  XLEN  core byte address
- core_wdata  in  XLEN  core store data
- core_wren  in  1  core store enable
- core_mode  in  2  core access size code
- core_stall  out  1  core must hold EX and re-present the request next cycle
- dbg_req  in  1  debug request; held until granted
- dbg_addr  in  XLEN  debug byte address, word aligned
- dbg_wdata  in  XLEN  debug store data
- dbg_wren  in  1  debug store enable
- dbg_gnt  out  1  request accepted this cycle
- dbg_rvalid  out  1  debug read data valid
- dbg_rdata  out  XLEN  debug read data
- mem_address  out  XLEN  to data_memory address
- mem_data  out  XLEN  to data_memory data
- mem_wren  out  1  to data_memory wren
- mem_mode  out  2  to data_memory mem_mode
- mem_q  in  XLEN  from data_memory q, valid one cycle after issue

Behaviour:
- Reset: reset is synchronous and active-high. It clears the following:
  - core_stall=0, dbg_gnt=0, dbg_rvalid=0, dbg_rdata=0.
  - Wait counter = 0, state = CORE_OWN, registered read-owner bit = 0.
  - A debug read issued in the cycle before reset produces no rvalid and must be reissued.
- Owner selection is combinational on current inputs. Exactly one of the following applies each cycle:
  - Core grant: core_req=1 and not forced.
    - mem_* follow core_* unchanged.
    - dbg_gnt=0, core_stall=0.
  - Debug grant: core_req=0 and dbg_req=1, or forced.
    - mem_address=dbg_addr, mem_data=dbg_wdata, mem_wren=dbg_wren, mem_mode=MEM_MODE_WORD.
    - dbg_gnt=1.
    - core_stall=1 only if core_req=1.
  - Idle: no request.
    - mem_* follow core_*, but mem_wren=0.
    - dbg_gnt=0, core_stall=0.
- Forced: state=DBG_FORCE, i.e. wait counter == STARVE_LIMIT and dbg_req=1.
- Wait counter (width clog2(STARVE_LIMIT+1)) is registered:
  - Increments when dbg_req=1 and dbg_gnt=0; saturates at STARVE_LIMIT.
  - Clears to 0 on dbg_gnt=1 or dbg_req=0.
- State machine:
  - CORE_OWN -> DBG_FORCE when the counter reaches STARVE_LIMIT.
  - DBG_FORCE -> CORE_OWN after exactly one cycle (the forced grant clears the counter).
  - If dbg_req drops while in DBG_FORCE, no grant is issued, there is no stall, and the state returns to CORE_OWN.
- core_stall is high for at most one cycle in any window of STARVE_LIMIT+1 cycles.
- Read return:
  - The read-owner bit registers (dbg_gnt and !dbg_wren).
  - The next cycle: dbg_rvalid=1, dbg_rdata=mem_q, captured on that edge and held until the next debug read return.
  - The core receives mem_q directly (fixed one-cycle latency, unchanged timing).
- Debug write: completes at grant; no rvalid.
- Simultaneous core and debug requests in CORE_OWN: core wins; the debug wait counter increments.
- The core's stall input must be ORed with hazard_detection_unit stall in the core. This block does not flush the pipeline.

Decomposition:
- Shared header mem_codes.h holds MEM_MODE_BYTE=2'b00, MEM_MODE_HALF=2'b01, MEM_MODE_WORD=2'b10. data_memory and control use the same header.
- Arbiter state codes are local parameters.
- One natural sub-module: starvation_counter, a saturating counter with clear and terminal-count output.

Test Plan:
- Reset with dbg_req=1, core_req=1 held across reset -> all outputs 0 during reset; first cycle after reset: core granted, counter=1.
- core_req=0, dbg read at address 0x40, memory word 0xDEADBEEF -> dbg_gnt=1 that cycle, mem_mode=2'b10, mem_wren=0; next cycle dbg_rvalid=1, dbg_rdata=0xDEADBEEF.
- core_req=1 continuously, dbg write of 0x12345678 to 0x80 with STARVE_LIMIT=8 -> dbg_gnt and core_stall both high on the 9th cycle only; mem_wren=1, mem_address=0x80; the core's re-presented store completes the following cycle.
- Core store byte (core_mode=2'b00) with dbg_req=0 -> mem_* equal core_* bit for bit; dbg_gnt=0, core_stall=0, dbg_rvalid=0.
- Forced state reached, then dbg_req drops in the same cycle -> no grant, core_stall=0, counter=0, core access passes through.
- Debug read granted, then reset asserted next cycle -> dbg_rvalid stays 0; after reset, reissued read returns correct data one cycle after grant.
